// File: rtl/lc3b_dm_cache_pkg.sv
// ============================================================================
//  Module  : lc3b_dm_cache_pkg
//  Brief   : Shared types and line helpers for the LC-3b direct-mapped cache
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3b_dm_cache_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [1:0]   lc3b_mem_wmask;
  typedef logic [8:0]   lc3b_cache_tag;
  typedef logic [2:0]   lc3b_cache_index;
  typedef logic [3:0]   lc3b_cache_offset;
  typedef logic [2:0]   lc3b_line_word_sel;
  typedef logic [127:0] lc3b_cache_line;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WB    = 2'd1,
    S_ALLOC = 2'd2
  } lc3b_cache_state;

  // Extract one 16-bit word from a line; word 0 sits in the low bits.
  function automatic lc3b_word get_word(input lc3b_cache_line line,
                                        input lc3b_line_word_sel sel);
    return line[{sel, 4'h0} +: 16];
  endfunction

  // Merge the enabled bytes of a CPU write into the selected word of a line.
  function automatic lc3b_cache_line merge_word(input lc3b_cache_line line,
                                                input lc3b_line_word_sel sel,
                                                input lc3b_word wdata,
                                                input lc3b_mem_wmask wmask);
    lc3b_cache_line r;
    r = line;
    if (wmask[0]) r[{sel, 4'h0} +: 8] = wdata[7:0];
    if (wmask[1]) r[{sel, 4'h8} +: 8] = wdata[15:8];
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lc3b_cache_array.sv
// ============================================================================
//  Module  : lc3b_cache_array
//  Brief   : 8-entry storage array, asynchronous read, synchronous write,
//            synchronous clear of every entry on reset
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3b_cache_array #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [2:0]       index,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [8];

  // Clear every entry on reset, otherwise write the addressed entry when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[index] <= din;
    end
  end

  assign dout = mem[index];

endmodule

`default_nettype wire

// File: rtl/lc3b_dm_cache.sv
// ============================================================================
//  Module  : lc3b_dm_cache
//  Brief   : Direct-mapped, write-back, write-allocate cache, 8 x 128-bit lines,
//            between the LC-3b CPU memory port and a 128-bit physical memory
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3b_dm_cache
  import lc3b_dm_cache_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  // CPU side
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_wmask,
  input  logic [15:0]  mem_wdata,
  output logic         mem_resp,
  output logic [15:0]  mem_rdata,
  // Physical memory side
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  lc3b_cache_state   state;

  lc3b_cache_tag     addr_tag;
  lc3b_cache_index   addr_index;
  lc3b_line_word_sel addr_word;
  logic              addr_bit0_unused;

  lc3b_cache_line    line_out;
  lc3b_cache_tag     tag_out;
  logic              valid_out;
  logic              dirty_out;

  logic              req;
  logic              hit;
  logic              idle_write_hit;
  logic              fill_done;

  logic              data_we;
  lc3b_cache_line    data_in;
  logic              meta_we;
  logic              dirty_we;
  logic              dirty_in;

  // Byte 0 of the CPU address never selects anything: accesses are word wide.
  assign addr_tag         = mem_address[15:7];
  assign addr_index       = mem_address[6:4];
  assign addr_word        = mem_address[3:1];
  assign addr_bit0_unused = mem_address[0];

  // A simultaneous read and write is treated as a write, so only the
  // presence of some request matters for hit/miss handling.
  assign req            = mem_read | mem_write;
  assign hit            = valid_out && (tag_out == addr_tag);
  assign idle_write_hit = (state == S_IDLE) && mem_write && hit;
  assign fill_done      = (state == S_ALLOC) && pmem_resp;

  // Zero-wait hits: the response is combinational while idle.
  assign mem_resp  = (state == S_IDLE) && req && hit;
  assign mem_rdata = get_word(line_out, addr_word);

  // Bus controls are pure decodes of the state register, so they drop the
  // cycle after reset and read/write can never overlap.
  assign pmem_write   = (state == S_WB);
  assign pmem_read    = (state == S_ALLOC);
  assign pmem_address = (state == S_WB) ? {tag_out, addr_index, 4'h0}
                                        : {mem_address[15:4], 4'h0};
  assign pmem_wdata   = line_out;

  // Array write enables and write data for hit merges, fills and writebacks.
  always_comb begin
    data_we  = 1'b0;
    data_in  = pmem_rdata;
    meta_we  = 1'b0;
    dirty_we = 1'b0;
    dirty_in = 1'b0;
    if (idle_write_hit) begin
      data_we  = 1'b1;
      data_in  = merge_word(line_out, addr_word, mem_wdata, mem_wmask);
      dirty_we = 1'b1;
      dirty_in = 1'b1;
    end else if (fill_done) begin
      data_we  = 1'b1;
      meta_we  = 1'b1;
      dirty_we = 1'b1;
    end else if ((state == S_WB) && pmem_resp) begin
      dirty_we = 1'b1;
    end
  end

  // Miss handling: write back a dirty victim, then fill, then retry in idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (req && !hit) begin
            state <= dirty_out ? S_WB : S_ALLOC;
          end
        end
        S_WB: begin
          if (pmem_resp) state <= S_ALLOC;
        end
        S_ALLOC: begin
          if (pmem_resp) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  lc3b_cache_array #(.WIDTH(128)) u_data (
    .clk   (clk),
    .reset (reset),
    .we    (data_we),
    .index (addr_index),
    .din   (data_in),
    .dout  (line_out)
  );

  lc3b_cache_array #(.WIDTH(9)) u_tag (
    .clk   (clk),
    .reset (reset),
    .we    (meta_we),
    .index (addr_index),
    .din   (addr_tag),
    .dout  (tag_out)
  );

  lc3b_cache_array #(.WIDTH(1)) u_valid (
    .clk   (clk),
    .reset (reset),
    .we    (meta_we),
    .index (addr_index),
    .din   (1'b1),
    .dout  (valid_out)
  );

  lc3b_cache_array #(.WIDTH(1)) u_dirty (
    .clk   (clk),
    .reset (reset),
    .we    (dirty_we),
    .index (addr_index),
    .din   (dirty_in),
    .dout  (dirty_out)
  );

endmodule

`default_nettype wire

// File: tb/tb_lc3b_dm_cache.sv
// ============================================================================
//  Module  : tb_lc3b_dm_cache
//  Brief   : Directed self-checking bench for lc3b_dm_cache with a
//            fixed-latency physical memory responder
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lc3b_dm_cache;

  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_wmask;
  logic [15:0]  mem_wdata;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  // Physical memory model: 4096 lines, line la word w initialised to its byte address.
  logic [127:0] pmem [4096];
  logic         resp_en;
  int           inject_req;
  int           inject_seen;
  int           resp_cnt;
  int           rd_cnt;
  int           wb_cnt;
  logic [15:0]  last_rd_addr;
  logic [15:0]  last_wb_addr;
  logic [127:0] last_wb_data;

  int           resp_pulses;
  int           both_high;

  int           n_assert;
  int           n_fail;

  lc3b_dm_cache dut (
    .clk          (clk),
    .reset        (reset),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wmask    (mem_wmask),
    .mem_wdata    (mem_wdata),
    .mem_resp     (mem_resp),
    .mem_rdata    (mem_rdata),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  // Memory responder: pulses pmem_resp after LAT cycles of a held request,
  // or once on demand for the spurious-response check.
  always @(negedge clk) begin
    if (pmem_resp) begin
      pmem_resp = 1'b0;
      resp_cnt  = 0;
    end else if (inject_req != inject_seen) begin
      inject_seen = inject_req;
      pmem_resp   = 1'b1;
    end else if (resp_en && (pmem_read || pmem_write)) begin
      resp_cnt++;
      if (resp_cnt == LAT) begin
        pmem_resp = 1'b1;
        if (pmem_write) begin
          pmem[pmem_address[15:4]] = pmem_wdata;
          wb_cnt++;
          last_wb_addr = pmem_address;
          last_wb_data = pmem_wdata;
        end else begin
          pmem_rdata = pmem[pmem_address[15:4]];
          rd_cnt++;
          last_rd_addr = pmem_address;
        end
      end
    end else begin
      resp_cnt = 0;
    end
  end

  // Protocol monitor: count CPU responses and illegal read+write overlap.
  always @(negedge clk) begin
    #2;
    if (mem_resp) resp_pulses++;
    if (pmem_read && pmem_write) both_high++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU access; cyc = cycles waited before mem_resp, -1 on timeout.
  task automatic access(input logic [15:0] a, input logic rd, input logic wr,
                        input logic [1:0] wm, input logic [15:0] wd,
                        output logic [15:0] rdata, output int cyc);
    @(negedge clk);
    mem_address = a;
    mem_read    = rd;
    mem_write   = wr;
    mem_wmask   = wm;
    mem_wdata   = wd;
    cyc         = 0;
    rdata       = 'x;
    #1;
    while (!mem_resp && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (mem_resp) rdata = mem_rdata;
    else          cyc   = -1;
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  logic [15:0] rdata;
  int          cyc;
  int          rd0;
  int          wb0;
  int          rp0;

  initial begin
    n_assert = 0; n_fail = 0;
    resp_pulses = 0; both_high = 0;
    rd_cnt = 0; wb_cnt = 0; resp_cnt = 0;
    inject_req = 0; inject_seen = 0;
    resp_en = 1'b1;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    last_rd_addr = '0; last_wb_addr = '0; last_wb_data = '0;
    for (int la = 0; la < 4096; la++) begin
      logic [11:0] lav;
      lav = 12'(la);
      for (int w = 0; w < 8; w++) begin
        logic [2:0] wv;
        wv = 3'(w);
        pmem[la][w*16 +: 16] = {lav, wv, 1'b0};
      end
    end
    pmem[12'h123][63:48] = 16'hBEEF;

    reset = 1'b1;
    mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_wmask = 2'b00; mem_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_mem_resp", 128'(mem_resp), 128'd0);
    check("reset_pmem_read", 128'(pmem_read), 128'd0);
    check("reset_pmem_write", 128'(pmem_write), 128'd0);
    reset = 1'b0;

    // 1) Clean miss fill, then the same word hits.
    access(16'h1236, 1, 0, 2'b00, 16'h0, rdata, cyc);
    check("t1_cycles", 128'(cyc), 128'd3);
    check("t1_rdata", 128'(rdata), 128'hBEEF);
    check("t1_fill_addr", 128'(last_rd_addr), 128'h1230);
    check("t1_no_wb", 128'(wb_cnt), 128'd0);
    access(16'h1236, 1, 0, 2'b00, 16'h0, rdata, cyc);
    check("t1_rehit_cycles", 128'(cyc), 128'd0);

    // 2) Low-byte write hit, no bus activity, merged read-back.
    rd0 = rd_cnt;
    access(16'h1230, 0, 1, 2'b01, 16'hA5C3, rdata, cyc);
    check("t2_write_cycles", 128'(cyc), 128'd0);
    access(16'h1230, 1, 0, 2'b00, 16'h0, rdata, cyc);
    check("t2_read_cycles", 128'(cyc), 128'd0);
    check("t2_merged", 128'(rdata), 128'h12C3);
    check("t2_no_pmem", 128'(rd_cnt - rd0 + wb_cnt), 128'd0);

    // 3) Conflict miss on a dirty line: writeback then fill.
    access(16'h5230, 1, 0, 2'b00, 16'h0, rdata, cyc);
    check("t3_cycles", 128'(cyc), 128'd6);
    check("t3_wb_count", 128'(wb_cnt), 128'd1);
    check("t3_wb_addr", 128'(last_wb_addr), 128'h1230);
    check("t3_wb_word0", 128'(last_wb_data[15:0]), 128'h12C3);
    check("t3_wb_word3", 128'(last_wb_data[63:48]), 128'hBEEF);
    check("t3_fill_addr", 128'(last_rd_addr), 128'h5230);
    check("t3_rdata", 128'(rdata), 128'h5230);

    // 4) Reset during writeback drops the bus and loses the dirty data.
    access(16'h5232, 0, 1, 2'b11, 16'h7777, rdata, cyc);
    check("t4_dirty_write", 128'(cyc), 128'd0);
    wb0 = wb_cnt;
    resp_en = 1'b0;
    @(negedge clk);
    mem_address = 16'h1230; mem_read = 1'b1;
    @(negedge clk); #1;
    check("t4_in_wb", 128'(pmem_write), 128'd1);
    check("t4_wb_addr", 128'(pmem_address), 128'h5230);
    reset = 1'b1;
    @(negedge clk); #1;
    check("t4_wb_dropped", 128'(pmem_write), 128'd0);
    check("t4_read_low", 128'(pmem_read), 128'd0);
    reset = 1'b0; mem_read = 1'b0; resp_en = 1'b1;
    access(16'h1230, 1, 0, 2'b00, 16'h0, rdata, cyc);
    check("t4_clean_miss", 128'(cyc), 128'd3);
    check("t4_rdata", 128'(rdata), 128'h12C3);
    access(16'h5232, 1, 0, 2'b00, 16'h0, rdata, cyc);
    check("t4_lost_cycles", 128'(cyc), 128'd3);
    check("t4_lost_data", 128'(rdata), 128'h5232);
    check("t4_no_wb", 128'(wb_cnt - wb0), 128'd0);

    // 5) Sweep all indices: 8 clean misses then 8 hits.
    rd0 = rd_cnt; wb0 = wb_cnt;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      a = 16'(i * 16);
      access(a, 1, 0, 2'b00, 16'h0, rdata, cyc);
      check($sformatf("t5_miss_cyc_%0d", i), 128'(cyc), 128'd3);
      check($sformatf("t5_miss_data_%0d", i), 128'(rdata), 128'(a));
    end
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      a = 16'(i * 16 + 14);
      access(a, 1, 0, 2'b00, 16'h0, rdata, cyc);
      check($sformatf("t5_hit_cyc_%0d", i), 128'(cyc), 128'd0);
      check($sformatf("t5_hit_data_%0d", i), 128'(rdata), 128'(a));
    end
    check("t5_fills", 128'(rd_cnt - rd0), 128'd8);
    check("t5_no_wb", 128'(wb_cnt - wb0), 128'd0);

    // Read+write together acts as a write; empty wmask still dirties the line.
    access(16'h0010, 1, 1, 2'b10, 16'hFFFF, rdata, cyc);
    check("rw_cycles", 128'(cyc), 128'd0);
    access(16'h0010, 1, 0, 2'b00, 16'h0, rdata, cyc);
    check("rw_rdata", 128'(rdata), 128'hFF10);
    access(16'h0020, 0, 1, 2'b00, 16'hDEAD, rdata, cyc);
    check("wm0_cycles", 128'(cyc), 128'd0);
    access(16'h0020, 1, 0, 2'b00, 16'h0, rdata, cyc);
    check("wm0_unchanged", 128'(rdata), 128'h0020);
    wb0 = wb_cnt;
    access(16'h0120, 1, 0, 2'b00, 16'h0, rdata, cyc);
    check("wm0_dirty_cycles", 128'(cyc), 128'd6);
    check("wm0_wb_addr", 128'(last_wb_addr), 128'h0020);
    check("wm0_wb_count", 128'(wb_cnt - wb0), 128'd1);

    // 6) Spurious pmem_resp in idle is ignored.
    @(posedge clk); #2;
    inject_req++;
    @(negedge clk); @(negedge clk); #1;
    check("t6_idle_read", 128'(pmem_read), 128'd0);
    check("t6_idle_write", 128'(pmem_write), 128'd0);
    access(16'h0000, 1, 0, 2'b00, 16'h0, rdata, cyc);
    check("t6_idle_hit", 128'(cyc), 128'd0);

    // 6b) Request dropped mid-fill: fill completes, no response.
    @(negedge clk);
    mem_address = 16'h0080; mem_read = 1'b1;
    @(negedge clk); #1;
    check("t6_in_alloc", 128'(pmem_read), 128'd1);
    rp0 = resp_pulses;
    mem_read = 1'b0;
    repeat (6) @(negedge clk);
    #3;
    check("t6_no_resp", 128'(resp_pulses - rp0), 128'd0);
    check("t6_back_idle", 128'(pmem_read), 128'd0);
    access(16'h0080, 1, 0, 2'b00, 16'h0, rdata, cyc);
    check("t6_filled_hit", 128'(cyc), 128'd0);
    check("t6_filled_data", 128'(rdata), 128'h0080);

    check("never_both_high", 128'(both_high), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
